// File: rtl/vm_multi.sv
// Multi-slot vending machine: coin credit, per-slot stock/price table,
// one-cycle vend and change-return pulses, all outputs registered.
module vm_multi #(
  parameter int N_ITEMS = 8,
  parameter int CNT_W   = 4,
  parameter int COST_W  = 8,
  parameter int BAL_W   = 16,
  localparam int IW     = $clog2(N_ITEMS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        coins,
  input  logic [IW-1:0]     buttons,
  input  logic              select,
  input  logic              cancel,
  input  logic [IW-1:0]     item,
  input  logic [CNT_W-1:0]  count,
  input  logic [COST_W-1:0] cost,
  input  logic              valid,
  output logic [IW-1:0]     product,
  output logic              vend,
  output logic [1:0]        status,
  output logic [BAL_W-1:0]  balance,
  output logic              refund,
  output logic [BAL_W-1:0]  change,
  output logic [COST_W-1:0] info
);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, REFUND} state_t;
  typedef enum logic [1:0] {ST_NONE, ST_VENDED, ST_POOR, ST_SOLDOUT} status_t;

  state_t              state_q;
  status_t             status_q;
  logic [BAL_W-1:0]    balance_q;
  logic [IW-1:0]       product_q;
  logic                vend_q;
  logic                refund_q;
  logic [BAL_W-1:0]    change_q;
  logic [COST_W-1:0]   info_q;
  logic [CNT_W-1:0]    stock_q [N_ITEMS];
  logic [COST_W-1:0]   price_q [N_ITEMS];
  logic [CNT_W-1:0]    stock_d [N_ITEMS];
  logic [COST_W-1:0]   price_d [N_ITEMS];

  logic [BAL_W-1:0]    coin_val;
  logic [BAL_W:0]      bal_sum;
  logic [BAL_W-1:0]    bal_coin;
  logic                sel_valid;
  logic [CNT_W-1:0]    sel_stock;
  logic [COST_W-1:0]   sel_price;
  logic                accept;
  logic                restock_ok;

  always_comb begin
    case (coins)
      2'b01:   coin_val = BAL_W'(5);
      2'b10:   coin_val = BAL_W'(10);
      2'b11:   coin_val = BAL_W'(25);
      default: coin_val = '0;
    endcase
    // A coin that would carry out of the credit register is simply not taken.
    bal_sum    = {1'b0, balance_q} + {1'b0, coin_val};
    bal_coin   = bal_sum[BAL_W] ? balance_q : bal_sum[BAL_W-1:0];
    sel_valid  = 32'(buttons) < N_ITEMS;
    sel_stock  = sel_valid ? stock_q[buttons] : '0;
    sel_price  = sel_valid ? price_q[buttons] : '0;
    accept     = (state_q == CREDIT) && select && !cancel && sel_valid &&
                 (sel_stock != '0) && (balance_q >= BAL_W'(sel_price));
    restock_ok = valid && (32'(item) < N_ITEMS);
  end

  always_comb begin : stock_next
    logic [CNT_W:0] s;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      s = {1'b0, stock_q[i]};
      if (accept && (buttons == IW'(i)))
        s = s - 1'b1;
      if (restock_ok && (item == IW'(i)))
        s = s + {1'b0, count};
      stock_d[i] = s[CNT_W] ? '1 : s[CNT_W-1:0];
      price_d[i] = (restock_ok && (item == IW'(i))) ? cost : price_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      status_q  <= ST_NONE;
      balance_q <= '0;
      product_q <= '0;
      vend_q    <= 1'b0;
      refund_q  <= 1'b0;
      change_q  <= '0;
      info_q    <= '0;
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
        stock_q[i] <= '0;
        price_q[i] <= '0;
      end
    end else begin
      vend_q    <= 1'b0;
      refund_q  <= 1'b0;
      product_q <= '0;
      change_q  <= '0;
      info_q    <= sel_price;
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
        stock_q[i] <= stock_d[i];
        price_q[i] <= price_d[i];
      end
      case (state_q)
        IDLE: begin
          balance_q <= coin_val;
          if (coins != 2'b00)
            state_q <= CREDIT;
        end
        CREDIT: begin
          balance_q <= bal_coin;
          if (cancel) begin
            state_q  <= REFUND;
            status_q <= ST_NONE;
            refund_q <= 1'b1;
            change_q <= bal_coin;
          end else if (select) begin
            if (!sel_valid || (sel_stock == '0)) begin
              status_q <= ST_SOLDOUT;
            end else if (balance_q < BAL_W'(sel_price)) begin
              status_q <= ST_POOR;
            end else begin
              state_q   <= VEND;
              status_q  <= ST_VENDED;
              balance_q <= bal_coin - BAL_W'(sel_price);
              vend_q    <= 1'b1;
              product_q <= buttons;
            end
          end
        end
        VEND: begin
          if (balance_q != '0) begin
            state_q  <= REFUND;
            refund_q <= 1'b1;
            change_q <= balance_q;
          end else begin
            state_q <= IDLE;
          end
        end
        REFUND: begin
          balance_q <= '0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign product = product_q;
  assign vend    = vend_q;
  assign status  = status_q;
  assign balance = balance_q;
  assign refund  = refund_q;
  assign change  = change_q;
  assign info    = info_q;

endmodule

// File: tb/tb_vm_multi.sv
// Scoreboarded bench for vm_multi: expected vend/refund events are queued at
// stimulus time and consumed when the DUT pulses; state is spot-checked directly.
module tb_vm_multi;

  localparam int N_ITEMS = 8;
  localparam int CNT_W   = 4;
  localparam int COST_W  = 8;
  localparam int BAL_W   = 16;
  localparam int IW      = $clog2(N_ITEMS);

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        coins;
  logic [IW-1:0]     buttons;
  logic              select;
  logic              cancel;
  logic [IW-1:0]     item;
  logic [CNT_W-1:0]  count;
  logic [COST_W-1:0] cost;
  logic              valid;
  logic [IW-1:0]     product;
  logic              vend;
  logic [1:0]        status;
  logic [BAL_W-1:0]  balance;
  logic              refund;
  logic [BAL_W-1:0]  change;
  logic [COST_W-1:0] info;

  int checks = 0;
  int errors = 0;
  int exp_vend_q[$];
  int exp_refund_q[$];

  vm_multi #(.N_ITEMS(N_ITEMS), .CNT_W(CNT_W), .COST_W(COST_W), .BAL_W(BAL_W)) dut (
    .clk(clk), .rst(rst), .coins(coins), .buttons(buttons), .select(select),
    .cancel(cancel), .item(item), .count(count), .cost(cost), .valid(valid),
    .product(product), .vend(vend), .status(status), .balance(balance),
    .refund(refund), .change(change), .info(info)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (vend === 1'b1) begin
      if (exp_vend_q.size() == 0) check_eq("vend_unexpected", 32'(vend), 0);
      else check_eq("vend_product", 32'(product), exp_vend_q.pop_front());
    end
    if (refund === 1'b1) begin
      if (exp_refund_q.size() == 0) check_eq("refund_unexpected", 32'(refund), 0);
      else check_eq("refund_change", 32'(change), exp_refund_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    coins  = 2'b00;
    select = 1'b0;
    cancel = 1'b0;
    valid  = 1'b0;
  endtask

  task automatic restock(input int slot, input int cnt, input int price);
    item  = IW'(slot);
    count = CNT_W'(cnt);
    cost  = COST_W'(price);
    valid = 1'b1;
    step();
  endtask

  task automatic coin(input logic [1:0] c);
    coins = c;
    step();
  endtask

  task automatic press(input int slot);
    buttons = IW'(slot);
    select  = 1'b1;
    step();
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; coins = '0; buttons = '0; select = 0; cancel = 0;
    item = '0; count = '0; cost = '0; valid = 0;
    step(); step();
    check_eq("rst_status", 32'(status), 0);
    check_eq("rst_balance", 32'(balance), 0);
    check_eq("rst_vend", 32'(vend), 0);
    check_eq("rst_refund", 32'(refund), 0);
    check_eq("rst_change", 32'(change), 0);
    check_eq("rst_product", 32'(product), 0);
    check_eq("rst_info", 32'(info), 0);
    rst = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      buttons = IW'(i);
      step();
      check_eq("rst_price_info", 32'(info), 0);
    end

    // Exact-price purchase, then drain the remaining stock of slot 2.
    restock(2, 3, 35);
    buttons = 3'd2;
    step();
    check_eq("info_slot2", 32'(info), 35);
    coin(2'b11);
    check_eq("idle_first_coin", 32'(balance), 25);
    coin(2'b10);
    check_eq("credit_add", 32'(balance), 35);
    exp_vend_q.push_back(2);
    press(2);
    check_eq("vend_status", 32'(status), 1);
    check_eq("vend_balance", 32'(balance), 0);
    check_eq("vend_pulse", 32'(vend), 1);
    step();
    check_eq("no_refund_exact", 32'(refund), 0);
    check_eq("vend_one_cycle", 32'(vend), 0);
    press(2);
    check_eq("idle_select_ignored", 32'(status), 1);
    for (int k = 0; k < 2; k++) begin
      coin(2'b11); coin(2'b10);
      exp_vend_q.push_back(2);
      press(2);
      step();
    end
    coin(2'b11); coin(2'b10);
    press(2);
    check_eq("slot2_sold_out", 32'(status), 3);
    check_eq("soldout_balance", 32'(balance), 35);
    exp_refund_q.push_back(35);
    do_cancel();
    check_eq("cancel_status", 32'(status), 0);
    step();
    check_eq("after_refund_bal", 32'(balance), 0);

    // Overpay yields change; coins during VEND/REFUND are not credited.
    restock(1, 5, 30);
    coin(2'b11); coin(2'b11);
    exp_vend_q.push_back(1);
    exp_refund_q.push_back(20);
    press(1);
    check_eq("overpay_balance", 32'(balance), 20);
    coins = 2'b11;
    step();
    check_eq("vend_coin_rejected", 32'(balance), 20);
    coins = 2'b11;
    step();
    check_eq("refund_clears_bal", 32'(balance), 0);
    step();
    check_eq("refund_coin_rejected", 32'(balance), 0);

    // Empty slot then cancel.
    coin(2'b11);
    press(5);
    check_eq("empty_slot_status", 32'(status), 3);
    check_eq("empty_slot_balance", 32'(balance), 25);
    exp_refund_q.push_back(25);
    do_cancel();
    step();

    // Insufficient credit; coin with select is credited but compare is pre-edge.
    restock(3, 4, 40);
    coin(2'b11); coin(2'b10);
    press(3);
    check_eq("poor_status", 32'(status), 2);
    check_eq("poor_balance", 32'(balance), 35);
    coins = 2'b01;
    press(3);
    check_eq("poor_again_status", 32'(status), 2);
    check_eq("poor_coin_balance", 32'(balance), 40);
    exp_vend_q.push_back(3);
    press(3);
    check_eq("poor_then_vend", 32'(status), 1);
    check_eq("poor_then_bal", 32'(balance), 0);
    step();

    // Restock concurrent with vend: saturating stock, old price charged.
    restock(4, 14, 5);
    coin(2'b01);
    item = 3'd4; count = 4'd5; cost = 8'd7; valid = 1'b1;
    exp_vend_q.push_back(4);
    press(4);
    check_eq("conc_old_price_bal", 32'(balance), 0);
    check_eq("conc_status", 32'(status), 1);
    step();
    buttons = 3'd4;
    step();
    check_eq("conc_new_price", 32'(info), 7);
    for (int k = 0; k < 15; k++) begin
      coin(2'b10);
      exp_vend_q.push_back(4);
      exp_refund_q.push_back(3);
      press(4);
      step();
      step();
    end
    coin(2'b10);
    press(4);
    check_eq("sat_stock_exhausted", 32'(status), 3);
    exp_refund_q.push_back(10);
    do_cancel();
    step();

    // Credit ceiling.
    for (int k = 0; k < 2621; k++) coin(2'b11);
    check_eq("bal_near_max", 32'(balance), 65525);
    coin(2'b11);
    check_eq("overflow_rejected", 32'(balance), 65525);
    coin(2'b10);
    check_eq("bal_exact_max", 32'(balance), 65535);
    coin(2'b01);
    check_eq("max_coin_rejected", 32'(balance), 65535);
    exp_refund_q.push_back(65535);
    do_cancel();
    step();

    // Reset during VEND with residual credit.
    restock(6, 3, 10);
    coin(2'b11);
    exp_vend_q.push_back(6);
    press(6);
    check_eq("pre_rst_balance", 32'(balance), 15);
    rst = 1'b1;
    step();
    check_eq("vrst_balance", 32'(balance), 0);
    check_eq("vrst_status", 32'(status), 0);
    check_eq("vrst_vend", 32'(vend), 0);
    check_eq("vrst_refund", 32'(refund), 0);
    check_eq("vrst_change", 32'(change), 0);
    check_eq("vrst_product", 32'(product), 0);
    check_eq("vrst_info", 32'(info), 0);
    rst = 1'b0;
    step();
    check_eq("vrst_no_refund", 32'(refund), 0);
    check_eq("vrst_price6", 32'(info), 0);
    buttons = 3'd4;
    step();
    check_eq("vrst_price4", 32'(info), 0);
    coin(2'b11);
    press(6);
    check_eq("vrst_stock6", 32'(status), 3);
    exp_refund_q.push_back(25);
    do_cancel();
    step();
    step();

    check_eq("vend_queue_empty", exp_vend_q.size(), 0);
    check_eq("refund_queue_empty", exp_refund_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
